// File: rtl/txn_ctrl_queue.sv
// Transaction control queue: splits segments into AXI INCR bursts,
// tracks data beats and write responses, and retires segments in order.
module txn_ctrl_queue #(
  parameter int unsigned Depth          = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned BeatCntWidth   = 12,
  parameter int unsigned BusBytesLog2   = 4,
  parameter int unsigned MaxBurstLen    = 256,
  parameter int unsigned BurstFifoDepth = 8,
  parameter int unsigned MaxOutB        = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    seg_valid_i,
  output logic                    seg_ready_o,
  input  logic [AddrWidth-1:0]    seg_addr_i,
  input  logic [BeatCntWidth-1:0] seg_beats_i,
  input  logic                    seg_is_load_i,
  input  logic                    seg_is_final_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AddrWidth-1:0]    ax_addr_o,
  output logic [7:0]              ax_len_o,
  output logic [2:0]              ax_size_o,
  output logic                    beat_valid_o,
  input  logic                    beat_ready_i,
  output logic                    beat_burst_last_o,
  output logic                    beat_seg_last_o,
  output logic                    beat_is_load_o,
  output logic                    beat_is_final_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  output logic                    idle_o
);

  localparam int unsigned QIW = $clog2(Depth);
  localparam int unsigned QPW = QIW + 1;
  localparam int unsigned FIW = $clog2(BurstFifoDepth);
  localparam int unsigned BIW = $clog2(MaxOutB);
  localparam int unsigned LW  = (BeatCntWidth > 13) ? BeatCntWidth : 13;
  localparam logic [AddrWidth-1:0] AMask =
    ~((AddrWidth'(1) << BusBytesLog2) - AddrWidth'(1));

  typedef struct packed {
    logic [7:0] len;
    logic       seg_last;
    logic       is_load;
    logic       is_final;
  } burst_t;

  logic [AddrWidth-1:0]    q_addr_q  [Depth];
  logic [BeatCntWidth-1:0] q_beats_q [Depth];
  logic [Depth-1:0]        q_load_q, q_final_q, q_done_q;
  logic [QIW:0]            enq_q, iss_q, dat_q, deq_q;

  logic                    loaded_q;
  logic [AddrWidth-1:0]    cur_addr_q;
  logic [BeatCntWidth-1:0] rem_q;

  burst_t                  bf_mem_q [BurstFifoDepth];
  logic [FIW:0]            bf_wr_q, bf_rd_q;
  logic [7:0]              cnt_q;

  logic [MaxOutB-1:0]      bt_mem_q;
  logic [BIW:0]            bt_wr_q, bt_rd_q;

  logic q_empty, q_full, enq_fire, deq_adv;
  logic iss_pend, iss_load, iss_last, ax_ok, ax_fire, aw_fire;
  logic [QIW-1:0] iss_idx, dat_idx, deq_idx, st_idx, idx_t;
  logic [QIW:0] q_count;
  logic st_hit;
  logic [AddrWidth-1:0] eff_addr, step;
  logic [BeatCntWidth-1:0] eff_rem;
  logic [12:0] pg_bytes;
  logic [LW-1:0] pg_beats, rem_ext, max_ext, blen;
  logic bf_empty, bf_full, beat_fire, dat_adv;
  burst_t bf_head;
  logic bt_empty, bt_full, b_fire, b_done;
  logic unused_dat_wrap;

  assign unused_dat_wrap = dat_q[QIW];

  assign iss_idx = iss_q[QIW-1:0];
  assign dat_idx = dat_q[QIW-1:0];
  assign deq_idx = deq_q[QIW-1:0];
  assign q_empty = (enq_q == deq_q);
  assign q_full  = (enq_q[QIW-1:0] == deq_idx) && (enq_q[QIW] != deq_q[QIW]);
  assign q_count = enq_q - deq_q;
  assign seg_ready_o = !q_full;
  assign enq_fire = seg_valid_i && seg_ready_o;
  assign deq_adv = !q_empty && q_done_q[deq_idx];

  assign eff_addr = loaded_q ? cur_addr_q : q_addr_q[iss_idx];
  assign eff_rem  = loaded_q ? rem_q : q_beats_q[iss_idx];
  assign pg_bytes = 13'd4096 - {1'b0, eff_addr[11:0]};
  assign pg_beats = LW'(pg_bytes >> BusBytesLog2);
  assign rem_ext  = LW'(eff_rem);
  assign max_ext  = LW'(MaxBurstLen);

  // Burst length: smallest of remaining beats, max burst, page room.
  always_comb begin
    blen = rem_ext;
    if (max_ext < blen) blen = max_ext;
    if (pg_beats < blen) blen = pg_beats;
  end

  assign step     = AddrWidth'(blen) << BusBytesLog2;
  assign iss_last = (rem_ext == blen);
  assign iss_pend = (iss_q != enq_q);
  assign iss_load = q_load_q[iss_idx];

  assign bf_empty = (bf_wr_q == bf_rd_q);
  assign bf_full  = (bf_wr_q[FIW-1:0] == bf_rd_q[FIW-1:0]) &&
                    (bf_wr_q[FIW] != bf_rd_q[FIW]);
  assign bt_empty = (bt_wr_q == bt_rd_q);
  assign bt_full  = (bt_wr_q[BIW-1:0] == bt_rd_q[BIW-1:0]) &&
                    (bt_wr_q[BIW] != bt_rd_q[BIW]);

  assign ax_ok      = iss_pend && !bf_full && (iss_load || !bt_full);
  assign ar_valid_o = ax_ok && iss_load;
  assign aw_valid_o = ax_ok && !iss_load;
  assign aw_fire    = aw_valid_o && aw_ready_i;
  assign ax_fire    = aw_fire || (ar_valid_o && ar_ready_i);
  assign ax_addr_o  = eff_addr;
  assign ax_len_o   = 8'(blen - LW'(1));
  assign ax_size_o  = 3'(BusBytesLog2);

  assign bf_head           = bf_mem_q[bf_rd_q[FIW-1:0]];
  assign beat_valid_o      = !bf_empty;
  assign beat_burst_last_o = (cnt_q == bf_head.len);
  assign beat_seg_last_o   = beat_burst_last_o && bf_head.seg_last;
  assign beat_is_load_o    = bf_head.is_load;
  assign beat_is_final_o   = bf_head.is_final;
  assign beat_fire         = beat_valid_o && beat_ready_i;
  assign dat_adv           = beat_fire && beat_seg_last_o;

  assign b_ready_o = !bt_empty;
  assign b_fire    = b_valid_i && b_ready_o;
  assign b_done    = b_fire && bt_mem_q[bt_rd_q[BIW-1:0]];

  assign idle_o = q_empty && bf_empty && bt_empty;

  // Locate the oldest queued store that has not yet completed.
  always_comb begin
    st_hit = 1'b0;
    st_idx = '0;
    idx_t  = '0;
    for (int i = 0; i < Depth; i++) begin
      idx_t = deq_idx + QIW'(i);
      if (!st_hit && (QPW'(i) < q_count) &&
          !q_load_q[idx_t] && !q_done_q[idx_t]) begin
        st_hit = 1'b1;
        st_idx = idx_t;
      end
    end
  end

  // Segment queue storage, pointers and completion flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        q_addr_q[i]  <= '0;
        q_beats_q[i] <= '0;
      end
      q_load_q  <= '0;
      q_final_q <= '0;
      q_done_q  <= '0;
      enq_q     <= '0;
      iss_q     <= '0;
      dat_q     <= '0;
      deq_q     <= '0;
    end else begin
      if (ax_fire && iss_last) iss_q <= iss_q + 1'b1;
      if (dat_adv) begin
        dat_q <= dat_q + 1'b1;
        if (beat_is_load_o) q_done_q[dat_idx] <= 1'b1;
      end
      if (b_done && st_hit) q_done_q[st_idx] <= 1'b1;
      if (deq_adv) deq_q <= deq_q + 1'b1;
      if (enq_fire) begin
        q_addr_q[enq_q[QIW-1:0]]  <= seg_addr_i & AMask;
        q_beats_q[enq_q[QIW-1:0]] <= seg_beats_i;
        q_load_q[enq_q[QIW-1:0]]  <= seg_is_load_i;
        q_final_q[enq_q[QIW-1:0]] <= seg_is_final_i;
        q_done_q[enq_q[QIW-1:0]]  <= 1'b0;
        enq_q <= enq_q + 1'b1;
      end
    end
  end

  // Issue engine: running address and beats left for the head segment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loaded_q   <= 1'b0;
      cur_addr_q <= '0;
      rem_q      <= '0;
    end else if (ax_fire) begin
      loaded_q   <= !iss_last;
      cur_addr_q <= eff_addr + step;
      rem_q      <= eff_rem - BeatCntWidth'(blen);
    end
  end

  // Burst FIFO between address issue and the data beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BurstFifoDepth; i++) bf_mem_q[i] <= '0;
      bf_wr_q <= '0;
      bf_rd_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (ax_fire) begin
        bf_mem_q[bf_wr_q[FIW-1:0]] <= '{len: ax_len_o, seg_last: iss_last,
                                       is_load: iss_load,
                                       is_final: q_final_q[iss_idx]};
        bf_wr_q <= bf_wr_q + 1'b1;
      end
      if (beat_fire) begin
        if (beat_burst_last_o) begin
          bf_rd_q <= bf_rd_q + 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  // Write-response tracker: one seg_last flag per outstanding AW.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bt_mem_q <= '0;
      bt_wr_q  <= '0;
      bt_rd_q  <= '0;
    end else begin
      if (aw_fire) begin
        bt_mem_q[bt_wr_q[BIW-1:0]] <= iss_last;
        bt_wr_q <= bt_wr_q + 1'b1;
      end
      if (b_fire) bt_rd_q <= bt_rd_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_txn_ctrl_queue.sv
// Scoreboard bench for txn_ctrl_queue: directed segments, monitor
// compares every AX and data-beat handshake against expected queues.
module tb_txn_ctrl_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic [31:0] seg_addr = '0;
  logic [11:0] seg_beats = '0;
  logic        seg_ld = 1'b0;
  logic        seg_fin = 1'b0;
  logic        aw_valid, ar_valid;
  logic        aw_ready = 1'b1;
  logic        ar_ready = 1'b1;
  logic [31:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic        beat_blast, beat_slast, beat_ld, beat_fin;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic        idle;

  int n_chk = 0;
  int n_fail = 0;
  logic [40:0] exp_ax[$];
  logic [3:0]  exp_beat[$];
  logic [40:0] e_ax;
  logic [3:0]  e_bt;

  txn_ctrl_queue dut (
    .clk_i(clk), .rst_i(rst),
    .seg_valid_i(seg_valid), .seg_ready_o(seg_ready),
    .seg_addr_i(seg_addr), .seg_beats_i(seg_beats),
    .seg_is_load_i(seg_ld), .seg_is_final_i(seg_fin),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .ax_addr_o(ax_addr), .ax_len_o(ax_len), .ax_size_o(ax_size),
    .beat_valid_o(beat_valid), .beat_ready_i(beat_ready),
    .beat_burst_last_o(beat_blast), .beat_seg_last_o(beat_slast),
    .beat_is_load_o(beat_ld), .beat_is_final_o(beat_fin),
    .b_valid_i(b_valid), .b_ready_o(b_ready),
    .idle_o(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ax(input logic [31:0] a, input logic [7:0] len,
                         input logic ld);
    exp_ax.push_back({ld, a, len});
  endtask

  task automatic push_burst(input int len, input logic sl, input logic ld,
                            input logic fin);
    for (int i = 0; i <= len; i++)
      exp_beat.push_back({i == len, (i == len) && sl, ld, fin});
  endtask

  // Monitor: handshakes seen at negedge complete on the next posedge.
  always @(negedge clk) begin
    if (!rst && ((ar_valid && ar_ready) || (aw_valid && aw_ready))) begin
      if (exp_ax.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ax_unexpected: addr 0x%0h len %0d", ax_addr, ax_len);
      end else begin
        e_ax = exp_ax.pop_front();
        check("ax", 64'({ar_valid, ax_addr, ax_len}), 64'(e_ax));
        check("ax_size", 64'(ax_size), 64'(4));
        check("ax_excl", 64'(aw_valid & ar_valid), 64'(0));
      end
    end
    if (!rst && beat_valid && beat_ready) begin
      if (exp_beat.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_unexpected: flags 0x%0h",
                 {beat_blast, beat_slast, beat_ld, beat_fin});
      end else begin
        e_bt = exp_beat.pop_front();
        check("beat", 64'({beat_blast, beat_slast, beat_ld, beat_fin}),
              64'(e_bt));
      end
    end
  end

  task automatic enq(input logic [31:0] a, input logic [11:0] b,
                     input logic ld, input logic fin);
    int t = 0;
    @(posedge clk);
    #1;
    seg_valid = 1'b1;
    seg_addr  = a;
    seg_beats = b;
    seg_ld    = ld;
    seg_fin   = fin;
    @(negedge clk);
    while (!seg_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("enq_accept", 64'(seg_ready), 64'(1));
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic send_b();
    int t = 0;
    @(posedge clk);
    #1;
    b_valid = 1'b1;
    @(negedge clk);
    while (!b_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("b_accept", 64'(b_ready), 64'(1));
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    int t = 0;
    while ((exp_ax.size() != 0 || exp_beat.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check(name, 64'(exp_ax.size() + exp_beat.size()), 64'(0));
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    wait_sb(name);
    @(negedge clk);
    while (!idle && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(idle), 64'(1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_valid", 64'(aw_valid), 64'(0));
    check("rst_ar_valid", 64'(ar_valid), 64'(0));
    check("rst_beat_valid", 64'(beat_valid), 64'(0));
    check("rst_b_ready", 64'(b_ready), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_seg_ready", 64'(seg_ready), 64'(1));
    rst = 1'b0;

    // Single 4-beat load
    push_ax(32'h1000, 8'd3, 1'b1);
    push_burst(3, 1'b1, 1'b1, 1'b1);
    enq(32'h1000, 12'd4, 1'b1, 1'b1);
    @(negedge clk);
    check("enq_to_ar", 64'(ar_valid), 64'(1));
    @(negedge clk);
    check("ar_to_beat", 64'(beat_valid), 64'(1));
    wait_idle("t1_idle");

    // 4 KiB split, unaligned low bits dropped
    push_ax(32'h1FC0, 8'd3, 1'b1);
    push_ax(32'h2000, 8'd3, 1'b1);
    push_burst(3, 1'b0, 1'b1, 1'b0);
    push_burst(3, 1'b1, 1'b1, 1'b0);
    enq(32'h1FC7, 12'd8, 1'b1, 1'b0);
    wait_idle("t2_idle");

    // MaxBurstLen split of a 300-beat store
    push_ax(32'h0, 8'd255, 1'b0);
    push_ax(32'h1000, 8'd43, 1'b0);
    push_burst(255, 1'b0, 1'b0, 1'b1);
    push_burst(43, 1'b1, 1'b0, 1'b1);
    enq(32'h0, 12'd300, 1'b0, 1'b1);
    wait_sb("t3_beats");
    @(negedge clk);
    check("t3_b_pending", 64'(b_ready), 64'(1));
    send_b();
    @(negedge clk);
    check("t3_wait_2nd_b", 64'(idle), 64'(0));
    send_b();
    wait_idle("t3_idle");

    // Full queue with AR blocked
    ar_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_ax(32'(k * 256), 8'd0, 1'b1);
      push_burst(0, 1'b1, 1'b1, k == 4);
      enq(32'(k * 256), 12'd1, 1'b1, k == 4);
    end
    @(negedge clk);
    check("full_seg_ready", 64'(seg_ready), 64'(0));
    check("full_ar_valid", 64'(ar_valid), 64'(1));
    check("ax_hold0", 64'(ax_addr), 64'(32'h100));
    @(negedge clk);
    check("ax_hold1", 64'({ax_addr, ax_len}), 64'({32'h100, 8'd0}));
    @(posedge clk);
    #1;
    seg_valid = 1'b1;
    seg_addr  = 32'h9990;
    seg_beats = 12'd1;
    seg_ld    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    seg_valid = 1'b0;
    ar_ready  = 1'b1;
    wait_idle("t4_idle");
    check("t4_seg_ready", 64'(seg_ready), 64'(1));

    // Store then load, B delayed
    push_ax(32'h3000, 8'd1, 1'b0);
    push_ax(32'h4000, 8'd1, 1'b1);
    push_burst(1, 1'b1, 1'b0, 1'b0);
    push_burst(1, 1'b1, 1'b1, 1'b1);
    enq(32'h3000, 12'd2, 1'b0, 1'b0);
    enq(32'h4000, 12'd2, 1'b1, 1'b1);
    wait_sb("t5_beats");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t5_wait_b", 64'(idle), 64'(0));
    check("t5_b_ready", 64'(b_ready), 64'(1));
    send_b();
    @(negedge clk);
    check("t5_retire0", 64'(idle), 64'(0));
    @(negedge clk);
    check("t5_retire1", 64'(idle), 64'(0));
    @(negedge clk);
    check("t5_retire2", 64'(idle), 64'(1));

    // Reset during beat 2 of a 4-beat load
    push_ax(32'h5000, 8'd3, 1'b1);
    exp_beat.push_back(4'b0011);
    exp_beat.push_back(4'b0011);
    enq(32'h5000, 12'd4, 1'b1, 1'b1);
    wait_sb("t6_two_beats");
    #1;
    check("t6_in_burst", 64'({beat_valid, beat_blast}), 64'(2'b10));
    rst = 1'b1;
    #1;
    check("t6_rst_valids",
          64'({aw_valid, ar_valid, beat_valid, b_ready}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle", 64'(idle), 64'(1));
    check("t6_seg_ready", 64'(seg_ready), 64'(1));
    repeat (5) @(negedge clk);
    check("sb_drain", 64'(exp_ax.size() + exp_beat.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
